// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: run-control and register-dump block for sccomp.
// Lets the CPU run until HALT_PC or a cycle budget is reached. It then
// freezes the CPU, reads all 32 GPRs through the debug port, and streams
// them out over a valid/ready interface.
module rf_dump_ctrl #(
  parameter logic [31:0] HALT_PC    = 32'h00000048,
  parameter int          MAX_CYCLES = 1000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      pc_i,
  output logic [4:0]       reg_sel_o,
  input  logic [31:0]      reg_data_i,
  output logic             cpu_en_o,
  output logic             dump_valid_o,
  input  logic             dump_ready_i,
  output logic [4:0]       dump_idx_o,
  output logic [31:0]      dump_data_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  // Bit 5 set means all 32 indices have been loaded into the output slot.
  logic [5:0]       scan_idx;
  logic             pc_hit;
  logic             budget_hit;
  logic             load;
  logic             accept;
  logic             last_accept;

  assign cycle_cnt_o = cycle_cnt;

  // Decode run/stop conditions, slot handshakes and the next state.
  always_comb begin
    pc_hit      = (pc_i == HALT_PC);
    budget_hit  = (cycle_cnt == MAX_CNT);
    cpu_en_o    = (state == RUN) && !pc_hit && !budget_hit;
    accept      = dump_valid_o && dump_ready_i;
    load        = (state == SCAN) && (!dump_valid_o || dump_ready_i) && !scan_idx[5];
    last_accept = (state == SCAN) && accept && scan_idx[5] && (dump_idx_o == 5'd31);
    reg_sel_o   = 5'd0;
    state_nxt   = state;
    case (state)
      RUN: begin
        if (pc_hit || budget_hit) begin
          state_nxt = SCAN;
        end else begin
          state_nxt = RUN;
        end
      end
      SCAN: begin
        reg_sel_o = scan_idx[4:0];
        if (last_accept) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Count cycles in which the CPU was allowed to execute.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= '0;
    end else if (cpu_en_o) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Flag a budget stop; a simultaneous PC match counts as a normal halt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_o <= 1'b0;
    end else if ((state == RUN) && !pc_hit && budget_hit) begin
      timeout_o <= 1'b1;
    end
  end

  // Output slot: load the next register, hold it under back-pressure, finish on the last accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_idx     <= 6'd0;
      dump_valid_o <= 1'b0;
      dump_idx_o   <= 5'd0;
      dump_data_o  <= 32'h0;
      done_o       <= 1'b0;
    end else begin
      if (load) begin
        dump_idx_o   <= scan_idx[4:0];
        dump_data_o  <= (scan_idx == 6'd0) ? 32'h0 : reg_data_i;
        dump_valid_o <= 1'b1;
        scan_idx     <= scan_idx + 6'd1;
      end else if (accept) begin
        dump_valid_o <= 1'b0;
      end
      if (last_accept) begin
        done_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rf_dump_ctrl.md
Name: rf_dump_ctrl

Overview:
Synthesizable run-control and register-dump block that sits directly downstream of sccomp. It consumes the PC and the reg_sel/reg_data debug port.
- While the program runs, it holds the CPU enabled and counts executed cycles.
- On reaching HALT_PC or MAX_CYCLES, it freezes the CPU and scans all 32 GPRs through reg_sel/reg_data.
- It streams the 32 values out over a valid/ready interface (to a UART/trace sink), then parks in DONE.

Parameters:
HALT_PC, 32'h00000048, PC value that ends the run; the instruction at this PC is not executed.
MAX_CYCLES, 1000, enabled-cycle budget before forced stop.
CNT_W, 16, width of cycle counter; MAX_CYCLES < 2^CNT_W.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
pc_i  in  32  current PC from sccomp.
reg_sel_o  out  5  register select to sccomp debug port.
reg_data_i  in  32  combinational read data for reg_sel_o, valid in the same cycle.
cpu_en_o  out  1  CPU clock-enable; 0 freezes PC and register file.
dump_valid_o  out  1  dump entry available.
dump_ready_i  in  1  sink accepts entry.
dump_idx_o  out  5  register index of current entry.
dump_data_o  out  32  register value of current entry.
done_o  out  1  all 32 entries accepted.
timeout_o  out  1  run ended by MAX_CYCLES, not HALT_PC.
cycle_cnt_o  out  CNT_W  enabled cycles executed.

Behaviour:
- Reset (async, rstn=0): state=RUN, cycle_cnt=0, scan_idx=0, dump_valid_o=0, dump_idx_o=0, dump_data_o=0, done_o=0, timeout_o=0, reg_sel_o=0.
  - cpu_en_o follows its combinational rule, so it is 1 unless pc_i==HALT_PC.
  - Reset mid-scan or in DONE aborts immediately; no partial-entry hold.
- States: RUN, SCAN, DONE.
- cpu_en_o = (state==RUN) && (pc_i!=HALT_PC) && (cycle_cnt!=MAX_CYCLES). It is combinational, so the halting instruction never executes.
- RUN:
  - Each edge with cpu_en_o=1: cycle_cnt++.
  - pc_i==HALT_PC → SCAN, timeout_o stays 0.
  - Else cycle_cnt==MAX_CYCLES → SCAN, timeout_o<=1.
  - If both hold, HALT_PC takes priority and timeout_o stays 0.
  - reg_sel_o=0 in RUN.
- SCAN:
  - reg_sel_o=scan_idx.
  - Output slot loads when (!dump_valid_o || dump_ready_i) && scan_idx not exhausted. On load:
    - dump_idx_o<=scan_idx
    - dump_data_o<=(scan_idx==0)?32'h0:reg_data_i (r0 forced to zero)
    - dump_valid_o<=1
    - scan_idx++
  - After index 31 has loaded, no further loads. When entry 31 is accepted (valid&&ready): dump_valid_o<=0, done_o<=1, state→DONE.
  - Under back-pressure (valid=1, ready=0), dump_idx_o and dump_data_o hold stable.
  - An accept with no new load clears dump_valid_o.
- Latency: PC match sampled in cycle T. SCAN starts in T+1, the first entry is valid in T+2, and with ready=1 throughput is 1 entry/cycle. Entry 31 is accepted in T+33 and done_o=1 from T+34.
- DONE: cpu_en_o=0, dump_valid_o=0, done_o=1, outputs frozen until reset. cycle_cnt_o holds its final value in SCAN and DONE.
- Width rules: cycle_cnt is unsigned CNT_W and never exceeds MAX_CYCLES. scan_idx is 6 bits, so completion is bit 5 set, not a 5-bit wrap.

Test Plan:
- Straight-line program of 18 instructions from PC 0 ending at 0x48, ready=1 → cpu_en_o drops in the same cycle PC=0x48. cycle_cnt_o=18, timeout_o=0, 32 entries idx 0..31 in consecutive cycles. Entry 0 data=0; each other entry matches the expected rf value. done_o rises 34 cycles after the match cycle.
- Same run with dump_ready_i toggling 1,0,0,1,… → every entry held stable while ready=0. Exactly 32 accepts, no duplicate or skipped idx. done_o only after the idx 31 accept.
- Infinite loop (beq $0,$0,-1) with MAX_CYCLES=1000 → cpu_en_o=0 at cycle_cnt_o=1000, timeout_o=1, full 32-entry dump follows.
- MAX_CYCLES reached on the same cycle pc_i==HALT_PC → timeout_o=0, dump proceeds normally.
- rstn pulsed low while idx 10 is pending (valid=1, ready=0) → dump_valid_o=0 and done_o=0 immediately, state=RUN, cycle_cnt_o=0. The program reruns and produces an identical 32-entry dump.
- HALT_PC=32'h0 with PC at 0 out of reset → cpu_en_o=0 from reset release, cycle_cnt_o=0, dump of the all-zero register file.
